// File: rtl/nios_system_onchip_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_onchip_ram_dp
// Brief    : Dual-port Avalon-MM on-chip RAM: byte-lane writes, 1/2-cycle
//            pipelined reads with readdatavalid, defined port collisions.
// Revision : 1.0
// ============================================================================
module nios_system_onchip_ram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int                  c_NB    = DATA_WIDTH / 8;
  localparam int                  c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                       w_en;
  logic [1:0][ADDR_WIDTH-1:0] w_addr;
  logic [1:0][c_IDX_W-1:0]    w_idx;
  logic [1:0][c_NB-1:0]       w_be;
  logic [1:0][DATA_WIDTH-1:0] w_wdata;
  logic [1:0]                 w_cs;
  logic [1:0]                 w_rd_req;
  logic [1:0]                 w_wr_req;
  logic [1:0]                 w_in_range;
  logic [1:0]                 w_wr_ok;
  logic [1:0]                 w_rd;
  logic [1:0][DATA_WIDTH-1:0] w_readdata;
  logic [1:0]                 w_readdatavalid;

  assign w_en     = clken & ~reset_req;
  assign w_addr   = {s2_address, s1_address};
  assign w_be     = {s2_byteenable, s1_byteenable};
  assign w_wdata  = {s2_writedata, s1_writedata};
  assign w_cs     = {s2_chipselect, s1_chipselect};
  assign w_rd_req = {s2_read, s1_read};
  assign w_wr_req = {s2_write, s1_write};

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int c_Q = 1 - p;

    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_valid1;

    assign w_in_range[p] = ({1'b0, w_addr[p]} < c_DEPTH);
    assign w_idx[p]      = w_addr[p][c_IDX_W-1:0];
    assign w_wr_ok[p]    = w_cs[p] & w_wr_req[p] & w_en & w_in_range[p];
    // read+write together is treated purely as a write
    assign w_rd[p]       = w_cs[p] & w_rd_req[p] & ~w_wr_req[p] & w_en;

    // Out-of-range reads return zero; in new-data mode the other port's
    // same-cycle write lanes are forwarded over the stored word.
    always_comb begin
      w_rdata = '0;
      if (w_in_range[p]) begin
        w_rdata = r_mem[w_idx[p]];
        if ((COLLISION_MODE == 1) && w_wr_ok[c_Q] && (w_addr[c_Q] == w_addr[p])) begin
          for (int b = 0; b < c_NB; b++) begin
            if (w_be[c_Q][b]) begin
              w_rdata[b*8 +: 8] = w_wdata[c_Q][b*8 +: 8];
            end
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid1 <= 1'b0;
        r_data1  <= '0;
      end else if (w_en) begin
        r_valid1 <= w_rd[p];
        if (w_rd[p]) begin
          r_data1 <= w_rdata;
        end
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_data2;
      logic                  r_valid2;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid2 <= 1'b0;
          r_data2  <= '0;
        end else if (w_en) begin
          r_valid2 <= r_valid1;
          if (r_valid1) begin
            r_data2 <= r_data1;
          end
        end
      end

      assign w_readdata[p]      = r_data2;
      assign w_readdatavalid[p] = r_valid2 & w_en;
    end else begin : g_lat1
      assign w_readdata[p]      = r_data1;
      assign w_readdatavalid[p] = r_valid1 & w_en;
    end
  end

  // s1 is applied last so it owns any lane both ports write
  always_ff @(posedge clk) begin
    for (int b = 0; b < c_NB; b++) begin
      if (w_wr_ok[1] && w_be[1][b]) begin
        r_mem[w_idx[1]][b*8 +: 8] <= w_wdata[1][b*8 +: 8];
      end
      if (w_wr_ok[0] && w_be[0][b]) begin
        r_mem[w_idx[0]][b*8 +: 8] <= w_wdata[0][b*8 +: 8];
      end
    end
  end

  assign s1_readdata      = w_readdata[0];
  assign s1_readdatavalid = w_readdatavalid[0];
  assign s2_readdata      = w_readdata[1];
  assign s2_readdatavalid = w_readdatavalid[1];

endmodule
`default_nettype wire

// File: tb/tb_nios_system_onchip_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_onchip_ram_dp
// Brief    : Two RAM configurations driven in lockstep against a
//            latency/queue reference model plus directed vectors.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_nios_system_onchip_ram_dp;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NB = 4;
  localparam int RL_A = 1, CM_A = 0, DEP_A = 4096;
  localparam int RL_B = 2, CM_B = 1, DEP_B = 3000;

  logic clk = 1'b0;
  logic reset, clken, reset_req;
  logic s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
  logic [AW-1:0] s1_a, s2_a;
  logic [NB-1:0] s1_be, s2_be;
  logic [DW-1:0] s1_wd, s2_wd;
  // index k = instance*2 + port (port 0 = s1)
  logic [3:0][DW-1:0] rdata;
  logic [3:0]         rvalid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios_system_onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP_A),
    .READ_LATENCY(RL_A), .COLLISION_MODE(CM_A)) u_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_a), .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
    .s1_byteenable(s1_be), .s1_writedata(s1_wd), .s1_readdata(rdata[0]), .s1_readdatavalid(rvalid[0]),
    .s2_address(s2_a), .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
    .s2_byteenable(s2_be), .s2_writedata(s2_wd), .s2_readdata(rdata[1]), .s2_readdatavalid(rvalid[1]));

  nios_system_onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP_B),
    .READ_LATENCY(RL_B), .COLLISION_MODE(CM_B)) u_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_a), .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
    .s1_byteenable(s1_be), .s1_writedata(s1_wd), .s1_readdata(rdata[2]), .s1_readdatavalid(rvalid[2]),
    .s2_address(s2_a), .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
    .s2_byteenable(s2_be), .s2_writedata(s2_wd), .s2_readdata(rdata[3]), .s2_readdatavalid(rvalid[3]));

  function automatic int rl_f(input int i); return (i == 0) ? RL_A : RL_B; endfunction
  function automatic int cm_f(input int i); return (i == 0) ? CM_A : CM_B; endfunction
  function automatic int dep_f(input int i); return (i == 0) ? DEP_A : DEP_B; endfunction

  task automatic check(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d] got=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A read becomes visible once it has seen READ_LATENCY enabled edges
  // (counting its own acceptance edge) and only while en is high.
  typedef struct { int stamp; logic [DW-1:0] d; } pend_t;
  pend_t pq [4][$];
  logic [DW-1:0] mm [2][4096];
  int ecnt = 0;

  logic          mx_en;
  logic          mx_wr [2];
  logic          mx_rd [2];
  logic [AW-1:0] mx_a  [2];
  logic [NB-1:0] mx_be [2];
  logic [DW-1:0] mx_wd [2];

  always @(posedge clk) begin
    mx_en = clken & ~reset_req;
    mx_a[0] = s1_a;  mx_be[0] = s1_be;  mx_wd[0] = s1_wd;
    mx_a[1] = s2_a;  mx_be[1] = s2_be;  mx_wd[1] = s2_wd;
    mx_wr[0] = s1_cs & s1_wr & mx_en;
    mx_wr[1] = s2_cs & s2_wr & mx_en;
    mx_rd[0] = s1_cs & s1_rd & ~s1_wr & mx_en;
    mx_rd[1] = s2_cs & s2_rd & ~s2_wr & mx_en;
    if (reset) begin
      for (int k = 0; k < 4; k++) pq[k].delete();
    end else if (mx_en) begin
      for (int k = 0; k < 4; k++)
        if (pq[k].size() > 0 && (ecnt - pq[k][0].stamp + 1 == rl_f(k / 2)))
          void'(pq[k].pop_front());
      ecnt++;
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (mx_rd[p]) begin
            pend_t e;
            e.stamp = ecnt;
            e.d = '0;
            if (int'(mx_a[p]) < dep_f(i)) begin
              e.d = mm[i][mx_a[p]];
              if (cm_f(i) == 1 && mx_wr[1-p] && mx_a[1-p] == mx_a[p])
                for (int b = 0; b < NB; b++)
                  if (mx_be[1-p][b]) e.d[b*8 +: 8] = mx_wd[1-p][b*8 +: 8];
            end
            pq[i*2+p].push_back(e);
          end
    end
    // s2 first, then s1, so s1 owns shared lanes
    for (int i = 0; i < 2; i++)
      for (int p = 1; p >= 0; p--)
        if (mx_wr[p] && int'(mx_a[p]) < dep_f(i))
          for (int b = 0; b < NB; b++)
            if (mx_be[p][b]) mm[i][mx_a[p]][b*8 +: 8] = mx_wd[p][b*8 +: 8];
  end

  // ---------------- monitor / scoreboard ----------------
  bit            mon_on = 1'b0;
  logic [DW-1:0] cap  [4];
  int            vcnt [4];
  initial for (int k = 0; k < 4; k++) begin cap[k] = '0; vcnt[k] = 0; end

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 4; k++) begin
        bit ev;
        ev = (clken & ~reset_req) && pq[k].size() > 0 &&
             (ecnt - pq[k][0].stamp + 1 == rl_f(k / 2));
        check("readdatavalid", k, {31'd0, rvalid[k]}, {31'd0, ev});
        if (ev) check("readdata", k, rdata[k], pq[k][0].d);
        if (rvalid[k]) begin
          cap[k] = rdata[k];
          vcnt[k]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_cs = 0; s1_rd = 0; s1_wr = 0; s1_a = '0; s1_be = '0; s1_wd = '0;
    s2_cs = 0; s2_rd = 0; s2_wr = 0; s2_a = '0; s2_be = '0; s2_wd = '0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)      return AW'($urandom_range(0, 15));
    else if (r < 9) return AW'($urandom_range(2995, 3004));
    else            return AW'(3500);
  endfunction

  typedef struct {
    bit w1; bit r1; logic [AW-1:0] a1; logic [NB-1:0] be1; logic [DW-1:0] d1;
    bit w2; bit r2; logic [AW-1:0] a2; logic [NB-1:0] be2; logic [DW-1:0] d2;
    bit chk; logic [DW-1:0] ea; logic [DW-1:0] eb;
  } vec_t;

  vec_t tbl [17];
  int   snap_a, snap_b;

  initial begin
    tbl[0]  = '{1,0,12'd5,   4'hF,32'hDEADBEEF, 0,0,12'd0,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[1]  = '{0,1,12'd5,   4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1,0,12'd7,   4'hF,32'h11223344, 0,0,12'd0,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[3]  = '{1,0,12'd7,   4'h5,32'hAABBCCDD, 0,0,12'd0,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[4]  = '{0,1,12'd7,   4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'h11BB33DD, 32'h11BB33DD};
    tbl[5]  = '{1,0,12'd9,   4'hF,32'h0,        0,0,12'd0,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[6]  = '{0,1,12'd9,   4'h0,32'h0,        1,0,12'd9,   4'hF,32'hCAFEF00D, 1,32'h0,        32'hCAFEF00D};
    tbl[7]  = '{1,0,12'd3,   4'hC,32'hFFFF0000, 1,0,12'd3,   4'hF,32'h12345678, 0,32'h0,        32'h0};
    tbl[8]  = '{0,1,12'd3,   4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'hFFFF5678, 32'hFFFF5678};
    tbl[9]  = '{1,0,12'd3500,4'hF,32'h55AA55AA, 0,0,12'd0,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[10] = '{0,1,12'd3500,4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'h55AA55AA, 32'h0};
    tbl[11] = '{0,0,12'd0,   4'h0,32'h0,        1,0,12'd2999,4'hF,32'h0BADCAFE, 0,32'h0,        32'h0};
    tbl[12] = '{0,1,12'd2999,4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'h0BADCAFE, 32'h0BADCAFE};
    tbl[13] = '{1,1,12'd11,  4'hF,32'h77777777, 0,0,12'd0,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[14] = '{0,1,12'd11,  4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'h77777777, 32'h77777777};
    tbl[15] = '{1,0,12'd9,   4'h3,32'h11112222, 0,1,12'd9,   4'h0,32'h0,        0,32'h0,        32'h0};
    tbl[16] = '{0,1,12'd5,   4'h0,32'h0,        0,0,12'd0,   4'h0,32'h0,        1,32'hDEADBEEF, 32'hDEADBEEF};

    reset = 1; clken = 1; reset_req = 0;
    idle();
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      check("reset_readdata", k, rdata[k], '0);
      check("reset_valid", k, {31'd0, rvalid[k]}, '0);
    end
    reset = 0;
    mon_on = 1;

    // give every address the random phase touches a known value
    for (int a = 0; a < 3020; a++) begin
      if (a < 16 || a >= 2990) begin
        s1_cs = 1; s1_wr = 1; s1_a = AW'(a); s1_be = 4'hF; s1_wd = 32'hA5000000 + a;
        step();
      end
    end
    s1_a = AW'(3500); step();
    idle();

    for (int i = 0; i < 17; i++) begin
      s1_cs = tbl[i].w1 | tbl[i].r1; s1_wr = tbl[i].w1; s1_rd = tbl[i].r1;
      s1_a = tbl[i].a1; s1_be = tbl[i].be1; s1_wd = tbl[i].d1;
      s2_cs = tbl[i].w2 | tbl[i].r2; s2_wr = tbl[i].w2; s2_rd = tbl[i].r2;
      s2_a = tbl[i].a2; s2_be = tbl[i].be2; s2_wd = tbl[i].d2;
      step();
      idle();
      if (tbl[i].chk) begin
        repeat (3) step();
        check("vec_s1_a", i, cap[0], tbl[i].ea);
        check("vec_s1_b", i, cap[2], tbl[i].eb);
      end
    end

    // stall: two reset_req cycles right after a read is accepted
    s1_cs = 1; s1_rd = 1; s1_a = 12'd5;
    step();
    idle();
    reset_req = 1;
    snap_a = vcnt[0]; snap_b = vcnt[2];
    repeat (2) step();
    reset_req = 0;
    repeat (4) step();
    check("stall_pulses_a", 0, 32'(vcnt[0] - snap_a), 32'd1);
    check("stall_pulses_b", 2, 32'(vcnt[2] - snap_b), 32'd1);
    check("stall_data_a", 0, cap[0], 32'hDEADBEEF);
    check("stall_data_b", 2, cap[2], 32'hDEADBEEF);

    // write while clken=0 must be dropped
    clken = 0;
    s1_cs = 1; s1_wr = 1; s1_a = 12'd5; s1_be = 4'hF; s1_wd = 32'h0;
    step();
    idle();
    clken = 1;
    s1_cs = 1; s1_rd = 1; s1_a = 12'd5;
    step();
    idle();
    repeat (3) step();
    check("clken_wr_a", 0, cap[0], 32'hDEADBEEF);
    check("clken_wr_b", 2, cap[2], 32'hDEADBEEF);

    // one-cycle reset while a read is in flight
    s1_cs = 1; s1_rd = 1; s1_a = 12'd7;
    step();
    idle();
    reset = 1;
    snap_a = vcnt[0]; snap_b = vcnt[2];
    step();
    reset = 0;
    repeat (3) step();
    check("rst_flight_a", 0, 32'(vcnt[0] - snap_a), 32'd1);
    check("rst_flight_b", 2, 32'(vcnt[2] - snap_b), 32'd0);
    for (int k = 0; k < 4; k++) check("rst_readdata", k, rdata[k], '0);

    // randomized phase, all checking done by the scoreboard
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      s1_cs = ($urandom_range(0, 3) != 0); s1_rd = 1'($urandom_range(0, 1));
      s1_wr = ($urandom_range(0, 2) == 0); s1_a = pick_addr();
      s1_be = 4'($urandom_range(0, 15));   s1_wd = $urandom;
      s2_cs = ($urandom_range(0, 3) != 0); s2_rd = 1'($urandom_range(0, 1));
      s2_wr = ($urandom_range(0, 2) == 0); s2_a = pick_addr();
      s2_be = 4'($urandom_range(0, 15));   s2_wd = $urandom;
      step();
    end
    reset = 0; clken = 1; reset_req = 0;
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
